// File: rtl/alu_op_pkg.sv
// Shared definitions for the ALU op sequencer: instruction field positions,
// select-code constants and the sequencer state encoding.
package alu_op_pkg;

  localparam int INS_W   = 16;
  localparam int LDI_BIT = 15;
  localparam int DST_BIT = 14;
  localparam int OPC_MSB = 14;
  localparam int OPC_LSB = 12;
  localparam int IMM_MSB = 13;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;
  localparam int SEL_W   = OPC_MSB - OPC_LSB + 1;
  localparam int CNT_W   = 16;

  localparam logic [SEL_W-1:0] OP_ADD  = 3'b000;
  localparam logic [SEL_W-1:0] OP_SUB  = 3'b001;
  localparam logic [SEL_W-1:0] OP_OR   = 3'b010;
  localparam logic [SEL_W-1:0] OP_AND  = 3'b011;
  localparam logic [SEL_W-1:0] OP_XOR  = 3'b100;
  localparam logic [SEL_W-1:0] OP_SHR  = 3'b101;
  localparam logic [SEL_W-1:0] OP_MOV  = 3'b110;
  localparam logic [SEL_W-1:0] OP_EXCH = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_regfile.sv
// Architectural RA/RB pair with independent write enables so a single edge
// can update one register or swap both.
module alu_op_regfile #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we_a,
  input  logic         we_b,
  input  logic [W-1:0] wd_a,
  input  logic [W-1:0] wd_b,
  output logic [W-1:0] ra,
  output logic [W-1:0] rb
);

  logic [W-1:0] ra_q, ra_d;
  logic [W-1:0] rb_q, rb_d;

  always_comb begin
    ra_d = ra_q;
    rb_d = rb_q;
    if (we_a) ra_d = wd_a;
    if (we_b) rb_d = wd_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_q <= '0;
      rb_q <= '0;
    end else begin
      ra_q <= ra_d;
      rb_q <= rb_d;
    end
  end

  assign ra = ra_q;
  assign rb = rb_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue side of the result-select interface: accepts LDI/ALU instruction words,
// drives RA/RB and a registered select code, and captures the selector results.
// Optional retirement counter is built when ALU_OP_SEQUENCER_CNT_EN is defined.
module alu_op_sequencer
  import alu_op_pkg::*;
#(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ins_valid,
  input  logic [INS_W-1:0] ins,
  output logic             ins_ready,
  output logic [W-1:0]     ra_o,
  output logic [W-1:0]     rb_o,
  output logic [SEL_W-1:0] sel_o,
  input  logic [W-1:0]     outA_i,
  input  logic [W-1:0]     outB_i,
  output logic             done,
`ifdef ALU_OP_SEQUENCER_CNT_EN
  output logic [CNT_W-1:0] retired_cnt,
`endif
  output logic             busy
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             done_q, done_d;
  logic             we_a, we_b;
  logic [W-1:0]     wd_a, wd_b;
  logic [W-1:0]     imm;

  assign imm = {{(W-IMM_W){1'b0}}, ins[IMM_MSB:IMM_LSB]};

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    we_a    = 1'b0;
    we_b    = 1'b0;
    wd_a    = outA_i;
    wd_b    = outB_i;
    unique case (state_q)
      ST_IDLE: begin
        if (ins_valid) begin
          if (ins[LDI_BIT]) begin
            // LDI retires on the accept edge; the FSM never leaves IDLE.
            done_d = 1'b1;
            if (ins[DST_BIT]) begin
              we_b = 1'b1;
              wd_b = imm;
            end else begin
              we_a = 1'b1;
              wd_a = imm;
            end
          end else begin
            sel_d   = ins[OPC_MSB:OPC_LSB];
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_CAPT;
      ST_CAPT: begin
        we_a    = 1'b1;
        we_b    = (sel_q == OP_EXCH);
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  alu_op_regfile #(.W(W)) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we_a  (we_a),
    .we_b  (we_b),
    .wd_a  (wd_a),
    .wd_b  (wd_b),
    .ra    (ra_o),
    .rb    (rb_o)
  );

`ifdef ALU_OP_SEQUENCER_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts alongside done so the count and the pulse become visible together.
  always_comb begin
    cnt_d = cnt_q;
    if (done_d) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign retired_cnt = cnt_q;
`endif

  assign ins_ready = (state_q == ST_IDLE);
  assign busy      = ~ins_ready;
  assign sel_o     = sel_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer with a behavioural register model and
// a reference result selector; covers ALU_OP_SEQUENCER_CNT_EN when defined.
module tb_alu_op_sequencer;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ins_valid = 1'b0;
  logic [15:0]   ins = '0;
  logic          ins_ready;
  logic [W-1:0]  ra_o, rb_o;
  logic [2:0]    sel_o;
  logic [W-1:0]  outA_i, outB_i;
  logic          done, busy;
  logic [W-1:0]  junk_b = '0;
`ifdef ALU_OP_SEQUENCER_CNT_EN
  logic [15:0]   retired_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_ra = '0, m_rb = '0;
  logic [15:0]  m_cnt = '0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ins_valid   (ins_valid),
    .ins         (ins),
    .ins_ready   (ins_ready),
    .ra_o        (ra_o),
    .rb_o        (rb_o),
    .sel_o       (sel_o),
    .outA_i      (outA_i),
    .outB_i      (outB_i),
    .done        (done),
`ifdef ALU_OP_SEQUENCER_CNT_EN
    .retired_cnt (retired_cnt),
`endif
    .busy        (busy)
  );

  // Opcode semantics on (A, B): result written to RA; EXCH also writes B <- A.
  function automatic logic [W-1:0] ref_a(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      3'd0: return W'(a + b);
      3'd1: return W'(a - b);
      3'd2: return a | b;
      3'd3: return a & b;
      3'd4: return a ^ b;
      3'd5: return a >> 1;
      default: return b;
    endcase
  endfunction

  // Reference selector; outB carries junk except for EXCH so stray RB writes show up.
  always_comb begin
    outA_i = ref_a(sel_o, ra_o, rb_o);
    outB_i = (sel_o == 3'd7) ? ra_o : junk_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".ra"}, 32'(ra_o), 32'(m_ra));
    check({tag, ".rb"}, 32'(rb_o), 32'(m_rb));
`ifdef ALU_OP_SEQUENCER_CNT_EN
    check({tag, ".cnt"}, 32'(retired_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic do_ldi(input logic dst, input logic [13:0] imm);
    @(negedge clk);
    check("ldi.ready_before", 32'(ins_ready), 32'd1);
    ins_valid = 1'b1;
    ins = {1'b1, dst, imm};
    @(posedge clk); #1;
    ins_valid = 1'b0;
    if (dst) m_rb = W'(imm); else m_ra = W'(imm);
    m_cnt++;
    check_regs("ldi");
    check("ldi.done", 32'(done), 32'd1);
    check("ldi.ready", 32'(ins_ready), 32'd1);
    $display("LDI %s <= %h", dst ? "RB" : "RA", imm);
  endtask

  task automatic do_alu(input logic [2:0] op);
    logic [W-1:0] a0, b0;
    a0 = m_ra;
    b0 = m_rb;
    junk_b = W'($urandom);
    @(negedge clk);
    check("alu.ready_before", 32'(ins_ready), 32'd1);
    ins_valid = 1'b1;
    ins = {1'b0, op, 12'($urandom)};
    @(posedge clk); #1;
    // Keep offering garbage while busy; it must be ignored.
    ins = 16'($urandom);
    check("alu.sel", 32'(sel_o), 32'(op));
    check("alu.busy1", 32'(busy), 32'd1);
    check("alu.done1", 32'(done), 32'd0);
    check_regs("alu.hold1");
    @(posedge clk); #1;
    check("alu.ready2", 32'(ins_ready), 32'd0);
    check("alu.done2", 32'(done), 32'd0);
    check_regs("alu.hold2");
    @(posedge clk); #1;
    ins_valid = 1'b0;
    m_ra = ref_a(op, a0, b0);
    if (op == 3'd7) m_rb = a0;
    m_cnt++;
    check_regs("alu.wb");
    check("alu.done3", 32'(done), 32'd1);
    check("alu.ready3", 32'(ins_ready), 32'd1);
    check("alu.sel_hold", 32'(sel_o), 32'(op));
    $display("ALU op=%0d A=%h B=%h -> RA=%h RB=%h", op, a0, b0, m_ra, m_rb);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    ins_valid = 1'b0;
    @(posedge clk); #1;
    check("idle.done", 32'(done), 32'd0);
    check("idle.ready", 32'(ins_ready), 32'd1);
    check_regs("idle");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("rst.ra", 32'(ra_o), 32'd0);
    check("rst.rb", 32'(rb_o), 32'd0);
    check("rst.sel", 32'(sel_o), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.ready", 32'(ins_ready), 32'd1);
    check("rst.busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) idle_cycle();

    do_ldi(1'b0, 14'h0005);
    do_ldi(1'b1, 14'h0003);
    do_alu(3'd0);
    idle_cycle();

    // Build RB=0xABCD from loadable immediates, then swap with RA=0x1234.
    do_ldi(1'b0, 14'h2BCD);
    do_ldi(1'b1, 14'h2000);
    for (int i = 0; i < 4; i++) do_alu(3'd0);
    do_alu(3'd7);
    do_ldi(1'b0, 14'h1234);
    do_alu(3'd7);
    check("exch.ra", 32'(ra_o), 32'h0000ABCD);
    check("exch.rb", 32'(rb_o), 32'h00001234);

    do_ldi(1'b0, 14'h0000);
    do_ldi(1'b1, 14'h0001);
    do_alu(3'd1);
    check("sub.wrap", 32'(ra_o), 32'h0000FFFF);
    do_alu(3'd5);
    check("shr", 32'(ra_o), 32'h00007FFF);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) do_ldi(1'($urandom), 14'($urandom));
      else do_alu(3'($urandom));
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    // Reset while an ADD is in ISSUE: writeback must be dropped.
    do_ldi(1'b0, 14'h0011);
    @(negedge clk);
    ins_valid = 1'b1;
    ins = 16'h0000;
    @(posedge clk); #1;
    ins_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    m_ra = '0;
    m_rb = '0;
    m_cnt = '0;
    check_regs("midrst");
    check("midrst.sel", 32'(sel_o), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.ready", 32'(ins_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle_cycle();
    $display("RESET during ISSUE dropped writeback");

`ifdef ALU_OP_SEQUENCER_CNT_EN
    do_ldi(1'b0, 14'h0002);
    @(negedge clk);
    ins_valid = 1'b1;
    ins = 16'h8001;
    repeat (65536) @(posedge clk);
    #1;
    ins_valid = 1'b0;
    m_ra = 16'h0001;
    check_regs("cnt.wrap");
    $display("CNT after 65536 LDI retirements = %h", retired_cnt);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
